sys_arr_tile: RTL and testbench
===============================

Name: sys_arr_tile

Overview:
Output-stationary systolic GEMM tile, ROWS x COLS PEs, and the parametrised successor to the fixed 8-bit PE array.
- Adds an internal operand-skew front end.
- Adds a programmable reduction length K and signed/unsigned mode.
- Adds a valid/ready row-by-row result drain.
- Sits between the operand SRAM streamers and the result writeback unit. Computes C[r][c] = sum over k of A[r][k]*W[k][c] per job.

Parameters:
ROWS, 16, PE rows; number of A lanes.
COLS, 16, PE columns; number of W lanes.
DATA_W, 8, operand width.
ACC_W, 32, accumulator width; must be >= 2*DATA_W.
K_W, 12, width of k_len; max K = 2^K_W-1.
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  job start; accepted only in IDLE.
k_len  in  K_W  reduction length, sampled with start; 0 is treated as 1.
in_valid  in  1  operand vector valid.
in_ready  out  1  high in LOAD only.
in_a  in  ROWS*DATA_W  A column k; lane r at bits [r*DATA_W +: DATA_W].
in_w  in  COLS*DATA_W  W row k; lane c at bits [c*DATA_W +: DATA_W].
out_valid  out  1  result row valid.
out_ready  in  1  downstream accepts row.
out_row  out  COLS*ACC_W  C[out_row_idx][*]; lane c at [c*ACC_W +: ACC_W].
out_row_idx  out  $clog2(ROWS)  row index of out_row.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse after the last row handshake.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_row=0, out_row_idx=0, busy=0, done=0. State is IDLE, all accumulators and skew/pipe registers are cleared.
- Reset mid-job aborts immediately. No done pulse is generated.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE: start=1 latches k_len (max(k_len,1)), clears all accumulators and moves to LOAD next cycle. start in other states is ignored.
- LOAD: in_ready=1. Each in_valid&in_ready cycle injects one vector and decrements the remaining count. Bubbles (in_valid=0) inject valid=0 and do not count. After the K-th beat, go to FLUSH.
- FLUSH: a counter runs ROWS+COLS-1 cycles so the last beat reaches PE[ROWS-1][COLS-1] and its MAC commits. Then go to DRAIN.
- DRAIN: out_valid=1 and row index i starts at 0. Each out_valid&out_ready beat advances i. Holding out_ready low holds out_row/out_row_idx stable. After the row ROWS-1 handshake: done=1 for one cycle, state goes to IDLE, out_valid=0.
- Skew: lane r of A is delayed r cycles before entering PE[r][0]; lane c of W is delayed c cycles before entering PE[0][c]. Each lane carries its own valid bit through the delay chain.
- PE behaviour:
  - A and its valid move right one PE per cycle; W and its valid move down one PE per cycle.
  - MAC executes only when both incoming valids are 1.
  - acc <= acc + ext(a*w).
- Arithmetic: the product is 2*DATA_W bits, signed or unsigned per SIGNED, sign/zero-extended to ACC_W. Accumulation wraps modulo 2^ACC_W with no saturation.
- Output mux: out_row is selected combinationally from accumulator row i. Accumulators do not change in DRAIN.
- Fixed latency from the last LOAD beat to the first out_valid: ROWS+COLS cycles.

Decomposition:
- Package sys_arr_pkg holds:
  - the state enum (IDLE, LOAD, FLUSH, DRAIN);
  - the localparams FLUSH_CYC = ROWS+COLS-1 and IDX_W = $clog2(ROWS);
  - the ext/mul helper function parameterised by SIGNED.
- Sub-module sys_pe contains one PE: a/w/valid pass-through registers plus the accumulator, with a clear input. The tile instantiates ROWS*COLS of them in a generate loop. Skew chains and the FSM live in the top module.

Test Plan:
1. Reset and idle:
   - Stimulus: rst held 3 cycles with in_valid=1 and start=0.
   - Required: all outputs 0, in_ready=0, no state change.
2. Identity check, ROWS=COLS=4, K=4, SIGNED=0:
   - Stimulus: A=I, W[k][c]=k*4+c+1.
   - Required: rows 0..3 out in order with C=W, done after 4th beat, first out_valid exactly 8 cycles after last LOAD beat.
3. Signed wrap, ACC_W=16, K=3:
   - Stimulus: all A=-128, all W=-128.
   - Required: 3*16384 mod 65536 = 49152 (0xC000) in every lane.
   - Same stimulus with SIGNED=0 reading 0x80: required 0xC000.
4. Bubbles and backpressure, K=5:
   - Stimulus: in_valid toggled 1,0,1,0... with A=1, W=2; out_ready low for 3 cycles on row 1.
   - Required: every C=10; row 1 data and index held stable while stalled; no row skipped or duplicated.
5. Reset mid-job:
   - Stimulus: rst asserted in FLUSH, then a new job with K=1, A=3, W=5.
   - Required: no done for the aborted job; all C=15 (no residue).
6. k_len=0 and start while busy:
   - Stimulus: start with k_len=0, then start pulses during LOAD/DRAIN.
   - Required: treated as K=1; extra starts ignored; exactly one done pulse.

Source files
------------

// File: rtl/sys_arr_tile_pkg.sv
// sys_arr_pkg: shared types and helpers for the sys_arr_tile systolic GEMM tile.
// Contents:
//   state_t      - tile controller states (IDLE, LOAD, FLUSH, DRAIN)
//   flush_cycles - cycles the last beat needs to reach the far-corner PE
//   idx_width    - width of a row index for a given row count
//   ext_op       - sign/zero-extend an operand of a given width to 64 bits
//   mul_ext      - extended product of two operands, signed or unsigned
package sys_arr_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  function automatic int flush_cycles(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  // A single-row tile still needs a one-bit index port.
  function automatic int idx_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic logic [63:0] ext_op(input logic [31:0] v, input int width,
                                         input bit is_signed);
    logic [63:0] r;
    r = {32'h0, v};
    if (is_signed && v[5'(width - 1)])
      r = r | ({64{1'b1}} << width);
    return r;
  endfunction

  // Both operands are extended to 64 bits first, so the low bits of the
  // product are correct for either signedness; callers truncate to ACC_W.
  function automatic logic [63:0] mul_ext(input logic [31:0] a, input logic [31:0] w,
                                          input int width, input bit is_signed);
    return ext_op(a, width, is_signed) * ext_op(w, width, is_signed);
  endfunction

endpackage

// File: rtl/sys_arr_tile_if.sv
// sys_arr_tile_if: job control, operand stream and result drain of the tile.
// Signals:
//   start, k_len            - job start and reduction length (sampled in IDLE)
//   in_valid/in_ready       - operand vector handshake, in_a (A column), in_w (W row)
//   out_valid/out_ready     - result row handshake, out_row data, out_row_idx
//   busy, done              - tile not idle, one-cycle job completion pulse
// Modports: master drives jobs and consumes results, slave is the tile.
interface sys_arr_tile_if
  import sys_arr_pkg::*;
#(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_W    = 12
);
  localparam int IDX_W = idx_width(ROWS);

  logic                     start;
  logic [K_W-1:0]           k_len;
  logic                     in_valid;
  logic                     in_ready;
  logic [ROWS*DATA_W-1:0]   in_a;
  logic [COLS*DATA_W-1:0]   in_w;
  logic                     out_valid;
  logic                     out_ready;
  logic [COLS*ACC_W-1:0]    out_row;
  logic [IDX_W-1:0]         out_row_idx;
  logic                     busy;
  logic                     done;

  modport master (
    output start, k_len, in_valid, in_a, in_w, out_ready,
    input  in_ready, out_valid, out_row, out_row_idx, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, in_a, in_w, out_ready,
    output in_ready, out_valid, out_row, out_row_idx, busy, done
  );
endinterface

// File: rtl/sys_arr_tile_pe.sv
// sys_pe: one processing element of the output-stationary array.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   clear                  - zero the accumulator (job start)
//   a_in/a_vld_in          - A operand from the left neighbour or skew chain
//   w_in/w_vld_in          - W operand from the upper neighbour or skew chain
//   a_out/a_vld_out        - registered A towards the right neighbour
//   w_out/w_vld_out        - registered W towards the lower neighbour
//   acc                    - accumulated dot product
module sys_pe
  import sys_arr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_vld_in,
  input  logic [DATA_W-1:0] w_in,
  input  logic              w_vld_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_vld_out,
  output logic [DATA_W-1:0] w_out,
  output logic              w_vld_out,
  output logic [ACC_W-1:0]  acc
);

  // The MAC fires only when both operands of the same beat arrive together;
  // the skew front end guarantees that alignment.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out     <= '0;
      a_vld_out <= 1'b0;
      w_out     <= '0;
      w_vld_out <= 1'b0;
      acc       <= '0;
    end else begin
      a_out     <= a_in;
      a_vld_out <= a_vld_in;
      w_out     <= w_in;
      w_vld_out <= w_vld_in;
      if (clear)
        acc <= '0;
      else if (a_vld_in && w_vld_in)
        acc <= acc + ACC_W'(mul_ext(32'(a_in), 32'(w_in), DATA_W, SIGNED != 0));
    end
  end

endmodule

// File: rtl/sys_arr_tile.sv
// sys_arr_tile: ROWS x COLS output-stationary systolic GEMM tile.
// Computes C[r][c] = sum_k A[r][k]*W[k][c] per job, then drains C row by row.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (aborts any job)
//   bus       - sys_arr_tile_if slave: job start/k_len, operand stream,
//               result row stream, busy and done
module sys_arr_tile
  import sys_arr_pkg::*;
#(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_W    = 12,
  parameter int SIGNED = 1
) (
  input  logic clk,
  input  logic rst,
  sys_arr_tile_if.slave bus
);
  localparam int FLUSH_CYC = flush_cycles(ROWS, COLS);
  localparam int IDX_W     = idx_width(ROWS);
  localparam int FL_W      = $clog2(FLUSH_CYC + 1);

  state_t             state_q, state_d;
  logic [K_W-1:0]     k_rem_q, k_rem_d;
  logic [FL_W-1:0]    flush_q, flush_d;
  logic [IDX_W-1:0]   row_q, row_d;
  logic               done_q, done_d;
  logic               clear_acc;
  logic               beat;

  // Operand/valid wires between PEs; index [r][c] is the input of PE[r][c].
  logic [DATA_W-1:0]  a_h  [ROWS][COLS+1];
  logic               av_h [ROWS][COLS+1];
  logic [DATA_W-1:0]  w_v  [ROWS+1][COLS];
  logic               wv_v [ROWS+1][COLS];
  logic [ACC_W-1:0]   acc  [ROWS][COLS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_rem_q <= '0;
      flush_q <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_rem_q <= k_rem_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  // Only handshaken beats count towards K; bubbles just inject valid=0.
  // FLUSH lets the last beat ripple to the far-corner PE before draining.
  always_comb begin
    state_d   = state_q;
    k_rem_d   = k_rem_q;
    flush_d   = flush_q;
    row_d     = row_q;
    done_d    = 1'b0;
    clear_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          clear_acc = 1'b1;
          k_rem_d   = (bus.k_len == '0) ? K_W'(1) : bus.k_len;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          k_rem_d = k_rem_q - K_W'(1);
          if (k_rem_q == K_W'(1)) begin
            state_d = FLUSH;
            flush_d = '0;
          end
        end
      end
      FLUSH: begin
        flush_d = flush_q + FL_W'(1);
        if (flush_q == FL_W'(FLUSH_CYC - 1)) begin
          state_d = DRAIN;
          row_d   = '0;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (row_q == IDX_W'(ROWS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            row_d   = '0;
          end else begin
            row_d = row_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign beat            = (state_q == LOAD) && bus.in_valid;
  assign bus.in_ready    = (state_q == LOAD);
  assign bus.out_valid   = (state_q == DRAIN);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.out_row_idx = row_q;

  // Lane r of A is delayed r cycles so that A[r][k] meets W[k][c] at PE[r][c].
  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    if (r == 0) begin : g_direct
      assign a_h[0][0]  = bus.in_a[0 +: DATA_W];
      assign av_h[0][0] = beat;
    end else begin : g_chain
      logic [DATA_W-1:0] dly   [r];
      logic              dly_v [r];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < r; i++) begin
            dly[i]   <= '0;
            dly_v[i] <= 1'b0;
          end
        end else begin
          dly[0]   <= bus.in_a[r*DATA_W +: DATA_W];
          dly_v[0] <= beat;
          for (int i = 1; i < r; i++) begin
            dly[i]   <= dly[i-1];
            dly_v[i] <= dly_v[i-1];
          end
        end
      end
      assign a_h[r][0]  = dly[r-1];
      assign av_h[r][0] = dly_v[r-1];
    end
  end

  // Lane c of W is delayed c cycles, mirroring the A skew.
  for (genvar c = 0; c < COLS; c++) begin : g_w_skew
    if (c == 0) begin : g_direct
      assign w_v[0][0]  = bus.in_w[0 +: DATA_W];
      assign wv_v[0][0] = beat;
    end else begin : g_chain
      logic [DATA_W-1:0] dly   [c];
      logic              dly_v [c];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < c; i++) begin
            dly[i]   <= '0;
            dly_v[i] <= 1'b0;
          end
        end else begin
          dly[0]   <= bus.in_w[c*DATA_W +: DATA_W];
          dly_v[0] <= beat;
          for (int i = 1; i < c; i++) begin
            dly[i]   <= dly[i-1];
            dly_v[i] <= dly_v[i-1];
          end
        end
      end
      assign w_v[0][c]  = dly[c-1];
      assign wv_v[0][c] = dly_v[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sys_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
      ) u_pe (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_acc),
        .a_in      (a_h[r][c]),
        .a_vld_in  (av_h[r][c]),
        .w_in      (w_v[r][c]),
        .w_vld_in  (wv_v[r][c]),
        .a_out     (a_h[r][c+1]),
        .a_vld_out (av_h[r][c+1]),
        .w_out     (w_v[r+1][c]),
        .w_vld_out (wv_v[r+1][c]),
        .acc       (acc[r][c])
      );
    end
  end

  // Result row is a plain mux over the frozen accumulators; zero outside DRAIN.
  always_comb begin
    bus.out_row = '0;
    if (state_q == DRAIN) begin
      for (int c = 0; c < COLS; c++)
        bus.out_row[c*ACC_W +: ACC_W] = acc[row_q][c];
    end
  end

endmodule

// File: tb/tb_sys_arr_tile.sv
// tb_sys_arr_tile: scoreboard bench for sys_arr_tile (4x4, 8-bit signed, 16-bit acc).
// Jobs push the expected C rows (plain matrix product) into a queue; a monitor
// pops and compares on every result handshake, and also checks latency,
// stall stability and done pulses.
module tb_sys_arr_tile;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int K_W    = 12;
  localparam int SIGNED = 1;
  localparam int MAXK   = 16;
  localparam int IDX_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef struct {
    int                    idx;
    logic [COLS*ACC_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sys_arr_tile_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_W(K_W)) bus ();

  sys_arr_tile #(
    .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_W(K_W), .SIGNED(SIGNED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_beat_cyc = 0;
  int done_cnt = 0;
  int stall_n = 0;
  int bp_mode = 0;
  exp_t exp_q[$];
  logic [DATA_W-1:0] job_a [ROWS][MAXK];
  logic [DATA_W-1:0] job_w [MAXK][COLS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic int sx(input logic [DATA_W-1:0] v);
    if (SIGNED != 0) return int'($signed(v));
    return int'(v);
  endfunction

  // Reference model: C = A x W over the first k beats, reduced mod 2^ACC_W.
  task automatic pushExpected(input int k);
    for (int r = 0; r < ROWS; r++) begin
      exp_t e;
      e.idx  = r;
      e.data = '0;
      for (int c = 0; c < COLS; c++) begin
        int s = 0;
        for (int kk = 0; kk < k; kk++) s += sx(job_a[r][kk]) * sx(job_w[kk][c]);
        e.data[c*ACC_W +: ACC_W] = ACC_W'(s);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_row: got row %0d, required none", bus.out_row_idx);
      return;
    end
    e = exp_q.pop_front();
    check("row_idx", 64'(bus.out_row_idx), 64'(e.idx));
    check("row_data", 64'(bus.out_row), 64'(e.data));
  endtask

  task automatic applyStimulus(input int k_len_val, input bit bubbles, input bit start_in_load);
    int eff = (k_len_val == 0) ? 1 : k_len_val;
    int b = 0;
    int guard = 0;
    bit v = 1'b1;
    pushExpected(eff);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.k_len = K_W'(k_len_val);
    @(posedge clk); #1;
    bus.start = start_in_load;
    bus.k_len = K_W'($urandom);
    while (b < eff && guard < 4*MAXK + 20) begin
      for (int r = 0; r < ROWS; r++)
        bus.in_a[r*DATA_W +: DATA_W] = v ? job_a[r][b] : DATA_W'($urandom);
      for (int c = 0; c < COLS; c++)
        bus.in_w[c*DATA_W +: DATA_W] = v ? job_w[b][c] : DATA_W'($urandom);
      bus.in_valid = v;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        last_beat_cyc = cyc;
        b++;
      end
      @(posedge clk); #1;
      v = bubbles ? !v : 1'b1;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    if (b < eff) begin
      checks++;
      errors++;
      $display("[TB] FAIL load_timeout: got %0d beats, required %0d", b, eff);
    end
  endtask

  task automatic waitDone();
    int d0 = done_cnt;
    int guard = 0;
    while (done_cnt == d0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    repeat (6) @(negedge clk);
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
    check("busy_after_done", 64'(bus.busy), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic fillRandom();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < MAXK; k++) job_a[r][k] = DATA_W'($urandom);
    for (int k = 0; k < MAXK; k++)
      for (int c = 0; c < COLS; c++) job_w[k][c] = DATA_W'($urandom);
  endtask

  task automatic fillConst(input logic [DATA_W-1:0] av, input logic [DATA_W-1:0] wv);
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < MAXK; k++) job_a[r][k] = av;
    for (int k = 0; k < MAXK; k++)
      for (int c = 0; c < COLS; c++) job_w[k][c] = wv;
  endtask

  // Result sink: always ready, stall row 1 for three cycles, or random backpressure.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0: bus.out_ready = 1'b1;
        1: begin
          if (bus.out_valid && bus.out_row_idx == IDX_W'(1) && stall_n < 3) begin
            bus.out_ready = 1'b0;
            stall_n++;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: scoreboard pops on handshake, plus latency/stall/done checks.
  logic                  prev_valid = 1'b0;
  logic                  held = 1'b0;
  logic                  last_final = 1'b0;
  logic [COLS*ACC_W-1:0] held_row;
  logic [IDX_W-1:0]      held_idx;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      held       = 1'b0;
      last_final = 1'b0;
    end else begin
      if (bus.done) begin
        done_cnt++;
        check("done_after_last_row", 64'(last_final), 64'd1);
      end
      if (bus.out_valid && !prev_valid)
        check("first_out_latency", 64'(cyc - last_beat_cyc), 64'(ROWS + COLS));
      if (held && bus.out_valid) begin
        check("stall_row_hold", 64'(bus.out_row), 64'(held_row));
        check("stall_idx_hold", 64'(bus.out_row_idx), 64'(held_idx));
      end
      last_final = bus.out_valid && bus.out_ready && (bus.out_row_idx == IDX_W'(ROWS - 1));
      if (bus.out_valid && bus.out_ready) begin
        checkOutput();
        held = 1'b0;
      end else if (bus.out_valid) begin
        held     = 1'b1;
        held_row = bus.out_row;
        held_idx = bus.out_row_idx;
      end else begin
        held = 1'b0;
      end
      prev_valid = bus.out_valid;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    int g;
    bus.start    = 1'b0;
    bus.k_len    = '0;
    bus.in_valid = 1'b1;
    bus.in_a     = '0;
    bus.in_w     = '0;
    rst          = 1'b1;

    // Reset held with in_valid high: every output stays at zero.
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_row", 64'(bus.out_row), 64'd0);
      check("rst_out_row_idx", 64'(bus.out_row_idx), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", 64'(bus.busy), 64'd0);
      check("idle_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;

    // Identity A, W[k][c] = k*COLS+c+1: C equals W.
    $display("[TB] identity job");
    bp_mode = 0;
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < MAXK; k++) job_a[r][k] = (r == k) ? DATA_W'(1) : DATA_W'(0);
    for (int k = 0; k < MAXK; k++)
      for (int c = 0; c < COLS; c++) job_w[k][c] = DATA_W'(k*COLS + c + 1);
    applyStimulus(4, 1'b0, 1'b0);
    waitDone();

    // -128 * -128 three times wraps to 0xC000.
    $display("[TB] signed wrap job");
    fillConst(8'h80, 8'h80);
    applyStimulus(3, 1'b0, 1'b0);
    waitDone();

    // Bubbles on input, row 1 stalled for three cycles.
    $display("[TB] bubbles and backpressure job");
    fillConst(8'd1, 8'd2);
    stall_n = 0;
    bp_mode = 1;
    applyStimulus(5, 1'b1, 1'b0);
    waitDone();
    check("stall_applied", 64'(stall_n), 64'd3);
    bp_mode = 0;

    // Abort during FLUSH, then a clean K=1 job.
    $display("[TB] reset mid-job");
    fillRandom();
    applyStimulus(6, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_idle", 64'(bus.busy), 64'd0);
    fillConst(8'd3, 8'd5);
    applyStimulus(1, 1'b0, 1'b0);
    waitDone();

    // k_len=0 runs as K=1; start held through LOAD and pulsed in DRAIN.
    $display("[TB] k_len zero and ignored starts");
    fillRandom();
    applyStimulus(0, 1'b0, 1'b1);
    g = 0;
    while (!bus.out_valid && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    bus.start = 1'b1;
    bus.k_len = K_W'(2);
    @(posedge clk); #1;
    bus.start = 1'b0;
    waitDone();

    // Random jobs with random bubbles and backpressure.
    $display("[TB] random jobs");
    bp_mode = 2;
    for (int j = 0; j < 6; j++) begin
      fillRandom();
      applyStimulus($urandom_range(1, MAXK), 1'($urandom_range(0, 1)), 1'b0);
      waitDone();
    end
    bp_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
